// File: rtl/cafea_payout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cafea_payout_pkg
// Purpose  : Shared definitions for the coffee-machine payout executor:
//            FSM state encodings, default parameter values and a small
//            constant helper used to size the shared job timer.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cafea_payout_pkg;

  // Default parameter values, also used by the vending FSM bench.
  localparam int C_CNT_W_DEF       = 3;
  localparam int C_BREW_CYCLES_DEF = 8;
  localparam int C_TIMEOUT_DEF     = 16;

  localparam int C_STATE_W = 3;

  typedef enum logic [C_STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_CUP   = 3'd1,
    S_COIN5 = 3'd2,
    S_COIN1 = 3'd3,
    S_GAP   = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cafea_payout_if.sv
`default_nettype none
// ============================================================================
// Module   : cafea_payout_if
// Purpose  : Bundle of request strobes, hopper handshake, actuator outputs
//            and debug/status signals of the payout executor.
// Ports    : EB/ER1/ER2   request strobes (drink, 1-leu, 5-leu)
//            hopper_ack   hopper has ejected the requested coin
//            cup_go, coin1_go, coin5_go   actuator enables
//            busy, ovf, jam, state        status / debug
//            pend_cup, pend_c1, pend_c5   pending job counts (debug)
//            master: strobe/hopper side, slave: payout executor
// Revision : 1.0  initial release
// ============================================================================
interface cafea_payout_if
  import cafea_payout_pkg::*;
#(
  parameter int CNT_W = C_CNT_W_DEF
) ();

  logic                 EB;
  logic                 ER1;
  logic                 ER2;
  logic                 hopper_ack;
  logic                 cup_go;
  logic                 coin1_go;
  logic                 coin5_go;
  logic                 busy;
  logic                 ovf;
  logic                 jam;
  logic [C_STATE_W-1:0] state;
  logic [CNT_W-1:0]     pend_cup;
  logic [CNT_W-1:0]     pend_c1;
  logic [CNT_W-1:0]     pend_c5;

  modport master (
    output EB, ER1, ER2, hopper_ack,
    input  cup_go, coin1_go, coin5_go, busy, ovf, jam, state,
    input  pend_cup, pend_c1, pend_c5
  );

  modport slave (
    input  EB, ER1, ER2, hopper_ack,
    output cup_go, coin1_go, coin5_go, busy, ovf, jam, state,
    output pend_cup, pend_c1, pend_c5
  );

endinterface
`default_nettype wire

// File: rtl/cafea_payout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cafea_payout_cnt
// Purpose  : Saturating up/down pending-job counter.
// Ports    : clk, reset   clock, async active-high reset
//            i_inc        one new request this cycle
//            i_dec        one job completed this cycle
//            o_count      current pending count
//            o_sat        count is at its maximum
// Revision : 1.0  initial release
// ============================================================================
module cafea_payout_cnt
  import cafea_payout_pkg::*;
#(
  parameter int CNT_W = C_CNT_W_DEF
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_inc,
  input  wire logic             i_dec,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_sat
);

  localparam logic [CNT_W-1:0] C_MAX  = '1;
  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Simultaneous inc and dec cancel out, so a completion never loses a
  // request even when the counter is full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= C_ZERO;
    end else if (i_inc && !i_dec) begin
      if (r_count != C_MAX) r_count <= r_count + C_ONE;
    end else if (i_dec && !i_inc) begin
      if (r_count != C_ZERO) r_count <= r_count - C_ONE;
    end
  end

  assign o_count = r_count;
  assign o_sat   = (r_count == C_MAX);

endmodule
`default_nettype wire

// File: rtl/cafea_payout.sv
`default_nettype none
// ============================================================================
// Module   : cafea_payout
// Purpose  : Payout executor. Queues drink / coin-return strobes in three
//            pending counters and serves them one at a time: the cup with a
//            timed hold, the coin hoppers with a ready/ack handshake guarded
//            by a timeout. Priority cup > 5-leu > 1-leu, with one idle GAP
//            cycle after every job. A hopper timeout parks the FSM in HALT.
// Ports    : clk    system clock
//            reset  asynchronous active-high reset
//            bus    cafea_payout_if.slave (strobes, ack, actuators, status)
// Revision : 1.0  initial release
// ============================================================================
module cafea_payout
  import cafea_payout_pkg::*;
#(
  parameter int CNT_W       = C_CNT_W_DEF,
  parameter int BREW_CYCLES = C_BREW_CYCLES_DEF,
  parameter int TIMEOUT     = C_TIMEOUT_DEF
) (
  input  wire logic      clk,
  input  wire logic      reset,
  cafea_payout_if.slave  bus
);

  // One timer serves both the brew hold and the hopper timeout.
  localparam int C_TMR_W = $clog2(f_max(BREW_CYCLES, TIMEOUT)) + 1;
  localparam logic [C_TMR_W-1:0] C_BREW_LAST = C_TMR_W'(BREW_CYCLES - 1);
  localparam logic [C_TMR_W-1:0] C_TO_LAST   = C_TMR_W'(TIMEOUT - 1);
  localparam logic [C_TMR_W-1:0] C_TMR_ONE   = C_TMR_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_ZERO  = '0;

  state_t              r_state;
  logic [C_TMR_W-1:0]  r_timer;
  logic                r_cup_go;
  logic                r_coin1_go;
  logic                r_coin5_go;
  logic                r_ovf;
  logic                r_jam;

  logic [CNT_W-1:0]    w_cnt_cup;
  logic [CNT_W-1:0]    w_cnt_c1;
  logic [CNT_W-1:0]    w_cnt_c5;
  logic                w_sat_cup;
  logic                w_sat_c1;
  logic                w_sat_c5;
  logic                w_dec_cup;
  logic                w_dec_c1;
  logic                w_dec_c5;
  logic                w_ovf_hit;

  // Job completions: last brew cycle, or ack sampled while the matching
  // coin is requested. Ack in any other state has no effect.
  assign w_dec_cup = (r_state == S_CUP)   && (r_timer == C_BREW_LAST);
  assign w_dec_c5  = (r_state == S_COIN5) && bus.hopper_ack;
  assign w_dec_c1  = (r_state == S_COIN1) && bus.hopper_ack;

  // A strobe is lost only when its counter is full and not draining now.
  assign w_ovf_hit = (bus.EB  && w_sat_cup && !w_dec_cup) ||
                     (bus.ER1 && w_sat_c1  && !w_dec_c1)  ||
                     (bus.ER2 && w_sat_c5  && !w_dec_c5);

  cafea_payout_cnt #(.CNT_W(CNT_W)) u_cnt_cup (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (bus.EB),
    .i_dec   (w_dec_cup),
    .o_count (w_cnt_cup),
    .o_sat   (w_sat_cup)
  );

  cafea_payout_cnt #(.CNT_W(CNT_W)) u_cnt_c1 (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (bus.ER1),
    .i_dec   (w_dec_c1),
    .o_count (w_cnt_c1),
    .o_sat   (w_sat_c1)
  );

  cafea_payout_cnt #(.CNT_W(CNT_W)) u_cnt_c5 (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (bus.ER2),
    .i_dec   (w_dec_c5),
    .o_count (w_cnt_c5),
    .o_sat   (w_sat_c5)
  );

  // Actuator enables are registered alongside the state so they drop
  // immediately on async reset and never see a path from the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_cup_go   <= 1'b0;
      r_coin1_go <= 1'b0;
      r_coin5_go <= 1'b0;
      r_ovf      <= 1'b0;
      r_jam      <= 1'b0;
    end else begin
      if (w_ovf_hit) r_ovf <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_cnt_cup != C_CNT_ZERO) begin
            r_state  <= S_CUP;
            r_cup_go <= 1'b1;
          end else if (w_cnt_c5 != C_CNT_ZERO) begin
            r_state    <= S_COIN5;
            r_coin5_go <= 1'b1;
          end else if (w_cnt_c1 != C_CNT_ZERO) begin
            r_state    <= S_COIN1;
            r_coin1_go <= 1'b1;
          end
        end

        S_CUP: begin
          if (r_timer == C_BREW_LAST) begin
            r_state  <= S_GAP;
            r_cup_go <= 1'b0;
          end else begin
            r_timer <= r_timer + C_TMR_ONE;
          end
        end

        S_COIN5, S_COIN1: begin
          // Ack wins over a timeout expiring on the same edge.
          if (bus.hopper_ack) begin
            r_state    <= S_GAP;
            r_coin1_go <= 1'b0;
            r_coin5_go <= 1'b0;
          end else if (r_timer == C_TO_LAST) begin
            r_state    <= S_HALT;
            r_jam      <= 1'b1;
            r_coin1_go <= 1'b0;
            r_coin5_go <= 1'b0;
          end else begin
            r_timer <= r_timer + C_TMR_ONE;
          end
        end

        S_GAP: begin
          r_state <= S_IDLE;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          r_state    <= S_IDLE;
          r_cup_go   <= 1'b0;
          r_coin1_go <= 1'b0;
          r_coin5_go <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cup_go   = r_cup_go;
  assign bus.coin1_go = r_coin1_go;
  assign bus.coin5_go = r_coin5_go;
  assign bus.ovf      = r_ovf;
  assign bus.jam      = r_jam;
  assign bus.state    = r_state;
  assign bus.busy     = (r_state != S_IDLE) || (w_cnt_cup != C_CNT_ZERO) ||
                        (w_cnt_c1 != C_CNT_ZERO) || (w_cnt_c5 != C_CNT_ZERO);
  assign bus.pend_cup = w_cnt_cup;
  assign bus.pend_c1  = w_cnt_c1;
  assign bus.pend_c5  = w_cnt_c5;

endmodule
`default_nettype wire

// File: tb/tb_cafea_payout.sv
`default_nettype none
// ============================================================================
// Module   : tb_cafea_payout
// Purpose  : Self-checking bench for cafea_payout. Directed scenarios
//            followed by random strobes/acks, all compared each cycle with a
//            job-level model (pending queues, pulse lengths, job order).
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_cafea_payout;
  import cafea_payout_pkg::*;

  localparam int BREW = 4;
  localparam int TMO  = 16;
  localparam int MAXC = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cafea_payout_if #(.CNT_W(3)) bus ();

  cafea_payout #(.CNT_W(3), .BREW_CYCLES(BREW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: pending jobs per kind, sticky flags, current pulse lengths.
  int m_cup, m_c1, m_c5;
  bit m_ovf, m_jam;
  int cup_len, c5_len, c1_len;
  int order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cup = 0; m_c1 = 0; m_c5 = 0;
    m_ovf = 0; m_jam = 0;
    cup_len = 0; c5_len = 0; c1_len = 0;
  endtask

  task automatic upd(inout int m, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (m == MAXC) m_ovf = 1'b1;
      else m++;
    end else if (dec && !inc) begin
      m--;
    end
  endtask

  task automatic do_reset();
    bus.EB = 0; bus.ER1 = 0; bus.ER2 = 0; bus.hopper_ack = 0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: apply inputs, advance, update the model and check.
  task automatic tick(input bit eb, input bit er1, input bit er2, input bit ack);
    bit wc, w5, w1, dc, d5, d1;
    int pc, p5, p1, lc, l5, l1;
    logic [2:0] pre, now, expk;
    bus.EB = eb; bus.ER1 = er1; bus.ER2 = er2; bus.hopper_ack = ack;
    wc = bus.cup_go; w5 = bus.coin5_go; w1 = bus.coin1_go;
    pc = m_cup; p5 = m_c5; p1 = m_c1;
    lc = cup_len; l5 = c5_len; l1 = c1_len;
    @(posedge clk);
    #1;
    dc = wc && (lc == BREW);
    d5 = w5 && ack;
    d1 = w1 && ack;
    if ((w5 && !ack && l5 == TMO) || (w1 && !ack && l1 == TMO)) m_jam = 1'b1;
    upd(m_cup, eb, dc);
    upd(m_c5, er2, d5);
    upd(m_c1, er1, d1);
    pre = {wc, w5, w1};
    now = {bus.cup_go, bus.coin5_go, bus.coin1_go};
    cup_len = now[2] ? lc + 1 : 0;
    c5_len  = now[1] ? l5 + 1 : 0;
    c1_len  = now[0] ? l1 + 1 : 0;

    chk("pend_cup", 32'(bus.pend_cup), 32'(m_cup));
    chk("pend_c5", 32'(bus.pend_c5), 32'(m_c5));
    chk("pend_c1", 32'(bus.pend_c1), 32'(m_c1));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("jam", 32'(bus.jam), 32'(m_jam));
    chk("onehot", 32'($countones(now) <= 1), 32'd1);
    if (now != pre && now != 3'b000) begin
      chk("gap_before_job", 32'(pre), 32'd0);
      expk = (pc != 0) ? 3'b100 : (p5 != 0) ? 3'b010 : 3'b001;
      chk("job_priority", 32'(now), 32'(expk));
      order.push_back(now[2] ? 1 : now[1] ? 2 : 3);
    end
    if (wc && !dc) chk("cup_held", 32'(now[2]), 32'd1);
    if (dc) chk("cup_release", 32'(now[2]), 32'd0);
    if (w5 && !ack && l5 < TMO) chk("coin5_held", 32'(now[1]), 32'd1);
    if (w1 && !ack && l1 < TMO) chk("coin1_held", 32'(now[0]), 32'd1);
    if (d5) chk("coin5_release", 32'(now[1]), 32'd0);
    if (d1) chk("coin1_release", 32'(now[0]), 32'd0);
    if (m_jam) chk("halt_quiet", 32'(now), 32'd0);
    if ((m_cup + m_c5 + m_c1) != 0 || now != 3'b000)
      chk("busy", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    int cnt;
    bit seen;
    bit eb, e1, e5, ak;

    // ---------------- reset values
    do_reset();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_cup", 32'(bus.cup_go), 32'd0);
    chk("rst_coin1", 32'(bus.coin1_go), 32'd0);
    chk("rst_coin5", 32'(bus.coin5_go), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_jam", 32'(bus.jam), 32'd0);
    tick(0, 0, 0, 0);

    // ---------------- single drink timing
    tick(1, 0, 0, 0);
    chk("sd_state0", 32'(bus.state), 32'd0);
    chk("sd_cup0", 32'(bus.cup_go), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick(0, 0, 0, 0);
      chk("sd_cup", 32'(bus.cup_go), 32'(i >= 1 && i <= 4));
      chk("sd_state", 32'(bus.state), (i <= 4) ? 32'd1 : (i == 5) ? 32'd4 : 32'd0);
      chk("sd_busy", 32'(bus.busy), 32'(i <= 5));
    end

    // ---------------- simultaneous requests: priority order
    order.delete();
    tick(1, 1, 1, 0);
    for (int i = 0; i < 80 && bus.busy; i++)
      tick(0, 0, 0, (c5_len == 2 || c1_len == 2));
    chk("prio_drain", 32'(bus.busy), 32'd0);
    chk("prio_jobs", 32'(order.size()), 32'd3);
    if (order.size() == 3) begin
      chk("prio_first", 32'(order[0]), 32'd1);
      chk("prio_second", 32'(order[1]), 32'd2);
      chk("prio_third", 32'(order[2]), 32'd3);
    end

    // ---------------- concurrent inc/dec on coin5
    order.delete();
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("cc_coin5_on", 32'(bus.coin5_go), 32'd1);
    tick(0, 0, 1, 1);
    chk("cc_pend", 32'(bus.pend_c5), 32'd1);
    chk("cc_gap", 32'(bus.state), 32'd4);
    seen = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      tick(0, 0, 0, (c5_len == 2));
      if (bus.coin5_go) seen = 1;
    end
    chk("cc_second", 32'(seen), 32'd1);
    chk("cc_pend_end", 32'(bus.pend_c5), 32'd0);
    chk("cc_busy_end", 32'(bus.busy), 32'd0);

    // ---------------- hopper jam
    tick(0, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 0, 0);
      if (bus.coin1_go) cnt++;
    end
    chk("jam_len", 32'(cnt), 32'd16);
    chk("jam_state", 32'(bus.state), 32'd5);
    chk("jam_flag", 32'(bus.jam), 32'd1);
    chk("jam_coin1", 32'(bus.coin1_go), 32'd0);
    chk("jam_pend", 32'(bus.pend_c1), 32'd1);

    // ---------------- saturation while halted
    for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);
    chk("sat_pend", 32'(bus.pend_cup), 32'd7);
    chk("sat_ovf", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    chk("sat_ovf_sticky", 32'(bus.ovf), 32'd1);
    chk("sat_halt", 32'(bus.state), 32'd5);

    // ---------------- async reset in the middle of a brew
    do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("ar_pre_cup", 32'(bus.cup_go), 32'd1);
    chk("ar_pre_pend", 32'(bus.pend_cup), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_cup_drop", 32'(bus.cup_go), 32'd0);
    chk("ar_state", 32'(bus.state), 32'd0);
    chk("ar_pend", 32'(bus.pend_cup), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    tick(0, 0, 0, 0);
    chk("ar_post_state", 32'(bus.state), 32'd0);
    chk("ar_post_busy", 32'(bus.busy), 32'd0);
    chk("ar_post_pend", 32'(bus.pend_cup), 32'd0);

    // ---------------- random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      eb = ($urandom_range(0, 9) == 0);
      e1 = ($urandom_range(0, 9) == 0);
      e5 = ($urandom_range(0, 9) == 0);
      if (c5_len > 0 || c1_len > 0)
        ak = ($urandom_range(0, 2) == 0) || (c5_len >= 12) || (c1_len >= 12);
      else
        ak = ($urandom_range(0, 3) == 0);
      tick(eb, e1, e5, ak);
    end
    for (int i = 0; i < 600 && bus.busy; i++)
      tick(0, 0, 0, (c5_len >= 2 || c1_len >= 2));
    chk("rand_drain", 32'(bus.busy), 32'd0);
    chk("rand_nojam", 32'(bus.jam), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
